// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: scoreboard-based dependency stall and branch
// freeze/flush sequencing for the 5-stage pipeline.
module hazard_stall_ctrl #(
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = 4,
  parameter int BR_TIMEOUT = 15,
  parameter int CNT_W      = 16
) (
  input  logic                I_CLOCK,
  input  logic                I_LOCK,
  input  logic                I_IssueValid,
  input  logic                I_IssueWritesDest,
  input  logic [IDX_W-1:0]    I_IssueDestIdx,
  input  logic                I_Src1Used,
  input  logic [IDX_W-1:0]    I_Src1Idx,
  input  logic                I_Src2Used,
  input  logic [IDX_W-1:0]    I_Src2Idx,
  input  logic                I_IsBranch,
  input  logic                I_WriteBackEnable,
  input  logic [IDX_W-1:0]    I_WriteBackRegIdx,
  input  logic                I_BranchResolved,
  input  logic                I_BranchTaken,
  output logic                O_DepStall,
  output logic                O_BranchStall,
  output logic                O_Flush,
  output logic                O_Issue,
  output logic [NUM_REGS-1:0] O_PendingMask,
  output logic [CNT_W-1:0]    O_StallCount,
  output logic                O_Error
);

  localparam int TW = $clog2(BR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BR_WAIT,
    FLUSH,
    ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] eff;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                haz;
  logic                idle;

  assign idle = (state_q == IDLE);

  // Writeback lands in the first half-cycle, so its register is no longer busy
  always_comb begin
    eff = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (I_WriteBackEnable && I_WriteBackRegIdx == IDX_W'(i))
        eff[i] = 1'b0;
    end
  end

  // RAW on either source or WAW on the destination; out-of-range never matches
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (eff[i]) begin
        if (I_Src1Used && I_Src1Idx == IDX_W'(i))
          haz = 1'b1;
        if (I_Src2Used && I_Src2Idx == IDX_W'(i))
          haz = 1'b1;
        if (I_IssueWritesDest && I_IssueDestIdx == IDX_W'(i))
          haz = 1'b1;
      end
    end
  end

  assign O_DepStall    = I_LOCK & I_IssueValid & idle & haz;
  assign O_Issue       = I_LOCK & I_IssueValid & idle & ~haz;
  assign O_BranchStall = ~idle;
  assign O_Flush       = (state_q == FLUSH);
  assign O_Error       = (state_q == ERROR);
  assign O_PendingMask = pend_q;
  assign O_StallCount  = cnt_q;

  // Scoreboard next state: clear on writeback, then set on issue so set wins
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (I_WriteBackEnable && I_WriteBackRegIdx == IDX_W'(i))
        pend_d[i] = 1'b0;
      if (O_Issue && I_IssueWritesDest && I_IssueDestIdx == IDX_W'(i))
        pend_d[i] = 1'b1;
    end
  end

  // Branch sequencer; resolution beats the timeout in the same cycle
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (O_Issue && I_IsBranch)
          state_d = BR_WAIT;
      end
      BR_WAIT: begin
        if (I_BranchResolved) begin
          state_d = I_BranchTaken ? FLUSH : IDLE;
          tmo_d   = '0;
        end else if (tmo_q == TW'(BR_TIMEOUT)) begin
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      ERROR: begin
        state_d = ERROR;
      end
    endcase
  end

  // Saturating stall-cycle counter for debug display
  always_comb begin
    cnt_d = cnt_q;
    if ((O_DepStall || O_BranchStall) && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // State registers with asynchronous clear
  always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state_q <= IDLE;
      pend_q  <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural scoreboard/branch model.
module tb_hazard_stall_ctrl;

  localparam int NR = 16;
  localparam int BT = 15;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_FLSH = 2;
  localparam int M_ERR  = 3;

  logic clk = 1'b0;
  logic lock;
  logic iv, iwd, s1u, s2u, isbr, wbe, res, tkn;
  logic [3:0] dst, s1, s2, wbi;

  logic dep, iss, bst, fl, er;
  logic [15:0] mask, cnt;
  logic dep4, iss4, bst4, fl4, er4;
  logic [15:0] mask4;
  logic [3:0] cnt4;

  int vecs = 0;
  int miss = 0;

  bit m_pend[NR];
  int m_mode, m_wait, m_cnt, m_cnt4;

  always #5 clk = ~clk;

  hazard_stall_ctrl u16 (
    .I_CLOCK(clk), .I_LOCK(lock),
    .I_IssueValid(iv), .I_IssueWritesDest(iwd),
    .I_IssueDestIdx(dst),
    .I_Src1Used(s1u), .I_Src1Idx(s1),
    .I_Src2Used(s2u), .I_Src2Idx(s2),
    .I_IsBranch(isbr),
    .I_WriteBackEnable(wbe), .I_WriteBackRegIdx(wbi),
    .I_BranchResolved(res), .I_BranchTaken(tkn),
    .O_DepStall(dep), .O_BranchStall(bst),
    .O_Flush(fl), .O_Issue(iss),
    .O_PendingMask(mask), .O_StallCount(cnt),
    .O_Error(er)
  );

  hazard_stall_ctrl #(.CNT_W(4)) u4 (
    .I_CLOCK(clk), .I_LOCK(lock),
    .I_IssueValid(iv), .I_IssueWritesDest(iwd),
    .I_IssueDestIdx(dst),
    .I_Src1Used(s1u), .I_Src1Idx(s1),
    .I_Src2Used(s2u), .I_Src2Idx(s2),
    .I_IsBranch(isbr),
    .I_WriteBackEnable(wbe), .I_WriteBackRegIdx(wbi),
    .I_BranchResolved(res), .I_BranchTaken(tkn),
    .O_DepStall(dep4), .O_BranchStall(bst4),
    .O_Flush(fl4), .O_Issue(iss4),
    .O_PendingMask(mask4), .O_StallCount(cnt4),
    .O_Error(er4)
  );

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_mode = M_IDLE;
    m_wait = 0;
    m_cnt  = 0;
    m_cnt4 = 0;
  endfunction

  function automatic bit busy(input logic [3:0] r);
    return m_pend[r] && !(wbe && wbi == r);
  endfunction

  function automatic bit hazard();
    return (s1u && busy(s1)) || (s2u && busy(s2)) || (iwd && busy(dst));
  endfunction

  // {dep, issue, branch_stall, flush, error}
  function automatic logic [4:0] exp_ctl();
    bit can;
    can = lock && iv && m_mode == M_IDLE;
    return {can && hazard(), can && !hazard(),
            m_mode != M_IDLE, m_mode == M_FLSH, m_mode == M_ERR};
  endfunction

  function automatic logic [15:0] exp_mask();
    logic [15:0] m;
    for (int i = 0; i < NR; i++) m[i] = m_pend[i];
    return m;
  endfunction

  function automatic void model_update();
    logic [4:0] e;
    if (!lock) begin
      model_reset();
      return;
    end
    e = exp_ctl();
    if (e[4] || e[2]) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (wbe) m_pend[wbi] = 1'b0;
    if (e[3] && iwd) m_pend[dst] = 1'b1;
    case (m_mode)
      M_IDLE: if (e[3] && isbr) begin
        m_mode = M_WAIT;
        m_wait = 0;
      end
      M_WAIT: begin
        m_wait++;
        if (res) m_mode = tkn ? M_FLSH : M_IDLE;
        else if (m_wait > BT) m_mode = M_ERR;
      end
      M_FLSH: m_mode = M_IDLE;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    {iv, iwd, dst, s1u, s1, s2u, s2, isbr, wbe, wbi, res, tkn} = '0;
  endtask

  task automatic do_reset();
    lock = 1'b0;
    quiet();
    tick();
    lock = 1'b1;
  endtask

  task automatic test_reset();
    lock = 1'b0;
    for (int k = 0; k < 6; k++) begin
      {iv, iwd, dst, s1u, s1, s2u, s2, isbr, wbe, wbi, res, tkn} = 24'($urandom);
      @(negedge clk);
      vecs++;
      if ({dep, iss, bst, fl, er, mask, cnt, cnt4} !== '0) begin
        miss++;
        $display("FAIL reset_hold got=%b exp=0", {dep, iss, bst, fl, er, mask, cnt, cnt4});
      end
      tick();
    end
    quiet();
    lock = 1'b1;
    iv = 1; isbr = 1; iwd = 1; dst = 4'd2;
    tick();
    quiet();
    @(negedge clk);
    vecs++;
    if ({bst, mask} !== {1'b1, 16'h0004}) begin
      miss++;
      $display("FAIL reset_prewait got=%b/%h exp=1/0004", bst, mask);
    end
    #2 lock = 1'b0;
    #1;
    vecs++;
    if ({bst, fl, er, mask} !== '0) begin
      miss++;
      $display("FAIL reset_async got=%b/%h exp=0/0000", {bst, fl, er}, mask);
    end
    model_reset();
    @(negedge clk);
    lock = 1'b1;
  endtask

  task automatic test_raw();
    quiet(); iv = 1; iwd = 1; dst = 4'd3;
    #2;
    vecs++;
    if ({dep, iss} !== 2'b01) begin
      miss++;
      $display("FAIL raw_first got=%b exp=01", {dep, iss});
    end
    tick();
    quiet(); iv = 1; s1u = 1; s1 = 4'd3;
    #2;
    vecs++;
    if (mask !== 16'h0008) begin
      miss++;
      $display("FAIL raw_mask got=%h exp=0008", mask);
    end
    vecs++;
    if ({dep, iss} !== 2'b10) begin
      miss++;
      $display("FAIL raw_stall got=%b exp=10", {dep, iss});
    end
    wbe = 1; wbi = 4'd3;
    #2;
    vecs++;
    if ({dep, iss} !== 2'b01) begin
      miss++;
      $display("FAIL raw_bypass got=%b exp=01", {dep, iss});
    end
    tick();
    quiet(); iv = 1; iwd = 1; dst = 4'd9;
    tick();
    quiet(); iv = 1; s2u = 1; s2 = 4'd9;
    #2;
    vecs++;
    if ({dep, iss, mask} !== {2'b10, 16'h0200}) begin
      miss++;
      $display("FAIL raw_src2 got=%b/%h exp=10/0200", {dep, iss}, mask);
    end
    s2u = 0; iwd = 1; dst = 4'd9;
    #2;
    vecs++;
    if ({dep, iss} !== 2'b10) begin
      miss++;
      $display("FAIL waw_stall got=%b exp=10", {dep, iss});
    end
    quiet(); wbe = 1; wbi = 4'd9;
    tick();
    quiet();
    #2;
    vecs++;
    if (mask !== 16'h0000) begin
      miss++;
      $display("FAIL raw_clear got=%h exp=0000", mask);
    end
  endtask

  task automatic test_collision();
    quiet(); iv = 1; iwd = 1; dst = 4'd5;
    tick();
    quiet(); iv = 1; iwd = 1; dst = 4'd5; wbe = 1; wbi = 4'd5;
    #2;
    vecs++;
    if ({dep, iss} !== 2'b01) begin
      miss++;
      $display("FAIL coll_issue got=%b exp=01", {dep, iss});
    end
    tick();
    quiet();
    #2;
    vecs++;
    if (mask !== 16'h0020) begin
      miss++;
      $display("FAIL coll_setwins got=%h exp=0020", mask);
    end
    wbe = 1; wbi = 4'd5;
    tick();
    quiet();
  endtask

  task automatic test_taken_branch();
    do_reset();
    iv = 1; isbr = 1;
    #2;
    vecs++;
    if ({iss, bst} !== 2'b10) begin
      miss++;
      $display("FAIL br_issue got=%b exp=10", {iss, bst});
    end
    tick();
    quiet();
    for (int k = 0; k < 3; k++) begin
      #2;
      vecs++;
      if ({bst, fl} !== 2'b10) begin
        miss++;
        $display("FAIL br_wait%0d got=%b exp=10", k, {bst, fl});
      end
      tick();
    end
    res = 1; tkn = 1;
    #2;
    vecs++;
    if ({bst, fl} !== 2'b10) begin
      miss++;
      $display("FAIL br_resolve got=%b exp=10", {bst, fl});
    end
    tick();
    quiet();
    #2;
    vecs++;
    if ({bst, fl} !== 2'b11) begin
      miss++;
      $display("FAIL br_flush got=%b exp=11", {bst, fl});
    end
    tick();
    #2;
    vecs++;
    if ({bst, fl, cnt} !== {2'b00, 16'd5}) begin
      miss++;
      $display("FAIL br_after got=%b cnt=%0d exp=00 cnt=5", {bst, fl}, cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    iv = 1; isbr = 1;
    tick();
    quiet();
    for (int k = 0; k < 15; k++) tick();
    res = 1; tkn = 0;
    #2;
    vecs++;
    if ({bst, er} !== 2'b10) begin
      miss++;
      $display("FAIL to_edge got=%b exp=10", {bst, er});
    end
    tick();
    quiet();
    #2;
    vecs++;
    if ({bst, er} !== 2'b00) begin
      miss++;
      $display("FAIL to_resolved got=%b exp=00", {bst, er});
    end
    iv = 1; isbr = 1;
    tick();
    quiet();
    for (int k = 0; k < 15; k++) tick();
    #2;
    vecs++;
    if ({bst, er} !== 2'b10) begin
      miss++;
      $display("FAIL to_pre got=%b exp=10", {bst, er});
    end
    tick();
    #2;
    vecs++;
    if ({bst, er} !== 2'b11) begin
      miss++;
      $display("FAIL to_error got=%b exp=11", {bst, er});
    end
    res = 1; tkn = 1;
    for (int k = 0; k < 3; k++) tick();
    quiet(); iv = 1;
    #2;
    vecs++;
    if ({iss, bst, fl, er} !== 4'b0101) begin
      miss++;
      $display("FAIL to_sticky got=%b exp=0101", {iss, bst, fl, er});
    end
    do_reset();
    #2;
    vecs++;
    if ({bst, er} !== 2'b00) begin
      miss++;
      $display("FAIL to_cleared got=%b exp=00", {bst, er});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    iv = 1; isbr = 1;
    tick();
    quiet();
    for (int k = 0; k < 20; k++) tick();
    #2;
    vecs++;
    if ({cnt4, cnt} !== {4'd15, 16'd20}) begin
      miss++;
      $display("FAIL sat got=%0d/%0d exp=15/20", cnt4, cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k % 150 == 149) do_reset();
      iv   = ($urandom_range(0, 9) < 7);
      iwd  = ($urandom_range(0, 9) < 6);
      dst  = 4'($urandom_range(0, 7));
      s1u  = $urandom_range(0, 1);
      s1   = 4'($urandom_range(0, 7));
      s2u  = $urandom_range(0, 1);
      s2   = 4'($urandom_range(0, 7));
      isbr = ($urandom_range(0, 9) < 1);
      wbe  = ($urandom_range(0, 9) < 4);
      wbi  = 4'($urandom_range(0, 7));
      res  = ($urandom_range(0, 9) < 3);
      tkn  = $urandom_range(0, 1);
      #2;
      vecs++;
      if ({dep, iss, bst, fl, er} !== exp_ctl()) begin
        miss++;
        $display("FAIL rnd_ctl@%0d got=%b exp=%b", k, {dep, iss, bst, fl, er}, exp_ctl());
      end
      vecs++;
      if (mask !== exp_mask()) begin
        miss++;
        $display("FAIL rnd_mask@%0d got=%h exp=%h", k, mask, exp_mask());
      end
      vecs++;
      if (cnt !== 16'(m_cnt)) begin
        miss++;
        $display("FAIL rnd_cnt@%0d got=%0d exp=%0d", k, cnt, m_cnt);
      end
      vecs++;
      if (cnt4 !== 4'(m_cnt4)) begin
        miss++;
        $display("FAIL rnd_cnt4@%0d got=%0d exp=%0d", k, cnt4, m_cnt4);
      end
      tick();
    end
  endtask

  initial begin
    lock = 1'b0;
    quiet();
    model_reset();
    test_reset();
    test_raw();
    test_collision();
    test_taken_branch();
    test_timeout();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
